// File: rtl/des_crypt_iter.sv
// Iterative DES engine: UNROLL rounds per clock, runtime encrypt/decrypt, req/ack handshake with abort.
// Optional CBC chaining (iv/chain ports, cv register) is enabled by defining DES_CBC_EN.
module des_crypt_iter #(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] k,
    input  logic [63:0] m,
    input  logic        dec,
    input  logic        req,
`ifdef DES_CBC_EN
    input  logic [63:0] iv,
    input  logic        chain,
`endif
    output logic [63:0] c,
    output logic        ack,
    output logic        busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
            $fatal(1, "des_crypt_iter: UNROLL must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Tables use DES numbering: entry value 1 is the MSB of the source vector.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2,
                                  59,51,43,35,27,19,11,3, 60,52,44,36,63,55,47,39,
                                  31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
                                  29,21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    // Each S-box is 64 nibbles indexed by {row, col}, entry 0 in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        for (int j = 0; j < 64; j++) perm_ip[63-j] = x[64-IP_T[j]];
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        for (int j = 0; j < 64; j++) perm_fp[63-j] = x[64-FP_T[j]];
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        for (int j = 0; j < 56; j++) perm_pc1[55-j] = x[64-PC1_T[j]];
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        for (int j = 0; j < 48; j++) perm_pc2[47-j] = x[56-PC2_T[j]];
    endfunction

    function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] sk);
        logic [47:0] e;
        logic [31:0] s;
        logic [5:0]  b;
        int          idx;
        for (int j = 0; j < 48; j++) e[47-j] = r[32-E_T[j]];
        e = e ^ sk;
        for (int i = 0; i < 8; i++) begin
            b   = e[47-6*i -: 6];
            idx = int'({b[5], b[0], b[4:1]});
            s[31-4*i -: 4] = SBOX[i][255-4*idx -: 4];
        end
        for (int j = 0; j < 32; j++) f_fn[31-j] = s[32-P_T[j]];
    endfunction

    // Rounds 0, 1, 8 and 15 rotate by one; all others by two.
    function automatic logic shift2(input logic [3:0] i);
        shift2 = !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
        rol28 = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
        ror28 = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] ck_q, ck_d, dk_q, dk_d;
    logic        dec_q, dec_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [63:0] c_q, c_d;
    logic        ack_q, ack_d, busy_q, busy_d;

    logic [31:0] l_n, r_n, t_r;
    logic [27:0] c_n, d_n;
    logic [47:0] sk;
    logic [3:0]  ri;
    logic [4:0]  rnd_sum;
    logic [63:0] ip_in, ip_o, res;
    logic [55:0] pc1_o;

`ifdef DES_CBC_EN
    logic [63:0] cv_q, cv_d, xv_q, xv_d, mi_q, mi_d, x_sel;
    assign x_sel = chain ? cv_q : iv;
    assign ip_in = dec ? m : (m ^ x_sel);
`else
    assign ip_in = m;
`endif

    assign ip_o    = perm_ip(ip_in);
    assign pc1_o   = perm_pc1(k);
    assign rnd_sum = rnd_q + 5'(UNROLL);

    // Decrypt consumes the current CD first and then undoes the mirrored round's rotation.
    always_comb begin
        l_n = l_q;
        r_n = r_q;
        c_n = ck_q;
        d_n = dk_q;
        sk  = '0;
        ri  = '0;
        t_r = '0;
        for (int u = 0; u < UNROLL; u++) begin
            ri = rnd_q[3:0] + 4'(u);
            if (dec_q) begin
                sk  = perm_pc2({c_n, d_n});
                c_n = ror28(c_n, shift2(4'd15 - ri));
                d_n = ror28(d_n, shift2(4'd15 - ri));
            end else begin
                c_n = rol28(c_n, shift2(ri));
                d_n = rol28(d_n, shift2(ri));
                sk  = perm_pc2({c_n, d_n});
            end
            t_r = r_n;
            r_n = l_n ^ f_fn(r_n, sk);
            l_n = t_r;
        end
    end

    assign res = perm_fp({r_n, l_n});

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        ck_d    = ck_q;
        dk_d    = dk_q;
        dec_d   = dec_q;
        rnd_d   = rnd_q;
        c_d     = c_q;
        ack_d   = ack_q;
`ifdef DES_CBC_EN
        cv_d    = cv_q;
        xv_d    = xv_q;
        mi_d    = mi_q;
`endif
        case (state_q)
            ST_IDLE: if (req) begin
                l_d     = ip_o[63:32];
                r_d     = ip_o[31:0];
                ck_d    = pc1_o[55:28];
                dk_d    = pc1_o[27:0];
                dec_d   = dec;
                rnd_d   = '0;
                state_d = ST_RUN;
`ifdef DES_CBC_EN
                xv_d    = x_sel;
                mi_d    = m;
`endif
            end
            ST_RUN: if (!req) begin
                state_d = ST_IDLE;
            end else begin
                l_d   = l_n;
                r_d   = r_n;
                ck_d  = c_n;
                dk_d  = d_n;
                rnd_d = rnd_sum;
                if (rnd_sum == 5'd16) begin
`ifdef DES_CBC_EN
                    c_d  = dec_q ? (res ^ xv_q) : res;
                    cv_d = dec_q ? mi_q : res;
`else
                    c_d  = res;
`endif
                    ack_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (!req) begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            ck_q    <= '0;
            dk_q    <= '0;
            dec_q   <= 1'b0;
            rnd_q   <= '0;
            c_q     <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DES_CBC_EN
            cv_q    <= '0;
            xv_q    <= '0;
            mi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            ck_q    <= ck_d;
            dk_q    <= dk_d;
            dec_q   <= dec_d;
            rnd_q   <= rnd_d;
            c_q     <= c_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef DES_CBC_EN
            cv_q    <= cv_d;
            xv_q    <= xv_d;
            mi_q    <= mi_d;
`endif
        end
    end

    assign c    = c_q;
    assign ack  = ack_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_des_crypt_iter.sv
// Directed bench for des_crypt_iter: three unroll factors, handshake, abort, async reset, optional CBC.
module tb_des_crypt_iter;
    logic        clk, rst;
    logic [63:0] k, m;
    logic        dec;
    logic        req1, req4, req16;
    logic [63:0] c1, c4, c16;
    logic        ack1, ack4, ack16, busy1, busy4, busy16;
`ifdef DES_CBC_EN
    logic [63:0] iv;
    logic        chain;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          sel = 0;
    logic [63:0] c_s;
    logic        ack_s, busy_s;

    des_crypt_iter #(.UNROLL(1)) dut1 (.clk(clk), .rst(rst), .k(k), .m(m), .dec(dec), .req(req1),
`ifdef DES_CBC_EN
        .iv(iv), .chain(chain),
`endif
        .c(c1), .ack(ack1), .busy(busy1));
    des_crypt_iter #(.UNROLL(4)) dut4 (.clk(clk), .rst(rst), .k(k), .m(m), .dec(dec), .req(req4),
`ifdef DES_CBC_EN
        .iv(iv), .chain(chain),
`endif
        .c(c4), .ack(ack4), .busy(busy4));
    des_crypt_iter #(.UNROLL(16)) dut16 (.clk(clk), .rst(rst), .k(k), .m(m), .dec(dec), .req(req16),
`ifdef DES_CBC_EN
        .iv(iv), .chain(chain),
`endif
        .c(c16), .ack(ack16), .busy(busy16));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    always_comb begin
        c_s    = c1;
        ack_s  = ack1;
        busy_s = busy1;
        case (sel)
            1: begin c_s = c4;  ack_s = ack4;  busy_s = busy4;  end
            2: begin c_s = c16; ack_s = ack16; busy_s = busy16; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int s, input logic v);
        case (s)
            1:       req4  = v;
            2:       req16 = v;
            default: req1  = v;
        endcase
    endtask

    // driver: one full transaction, inputs scrambled after the load edge
    task automatic do_op(input int s, input logic [63:0] kk, input logic [63:0] mm, input logic dd,
                         input logic chk_c, input logic [63:0] exp, input int exp_lat,
                         input int hold, input string tag, output logic [63:0] got);
        int lat, bcnt;
        sel = s;
        k   = kk;
        m   = mm;
        dec = dd;
        set_req(s, 1'b1);
        @(posedge clk);
        #1;
        k   = {$urandom, $urandom};
        m   = {$urandom, $urandom};
        dec = 1'($urandom_range(0, 1));
`ifdef DES_CBC_EN
        iv    = {$urandom, $urandom};
        chain = 1'($urandom_range(0, 1));
`endif
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (ack_s) break;
            if (busy_s) bcnt++;
            lat++;
        end
        got = c_s;
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busycnt"}, 64'(bcnt), 64'(exp_lat));
        check({tag, "_busy_done"}, 64'(busy_s), 64'd0);
        if (chk_c) check({tag, "_c"}, c_s, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_ack"}, 64'(ack_s), 64'd1);
            check({tag, "_hold_c"}, c_s, got);
        end
        set_req(s, 1'b0);
        @(negedge clk);
        check({tag, "_ack_fall"}, 64'(ack_s), 64'd0);
        check({tag, "_c_keep"}, c_s, got);
    endtask

    initial begin
        logic [63:0] got;
        logic        seen;
`ifdef DES_CBC_EN
        logic [63:0] c2;
        iv    = '0;
        chain = 1'b0;
`endif
        rst   = 1'b0;
        k     = '0;
        m     = '0;
        dec   = 1'b0;
        req1  = 1'b0;
        req4  = 1'b0;
        req16 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_c1", c1, 64'd0);
        check("rst_ack1", 64'(ack1), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_c4", c4, 64'd0);
        check("rst_c16", c16, 64'd0);
        check("rst_ack16", 64'(ack16), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405, 16, 0, "enc1", got);
        do_op(0, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 1'b1, 64'h0123456789ABCDEF, 16, 5, "dec1", got);
        do_op(0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405, 16, 0, "b2b", got);

        do_op(1, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 1'b1, 64'h0000000000000000, 4, 0, "enc_u4", got);
        do_op(2, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 1'b1, 64'h0000000000000000, 1, 2, "enc_u16", got);
        do_op(1, 64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 1'b1, 64'h8787878787878787, 4, 0, "dec_u4", got);
        do_op(2, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 1'b1, 64'h0123456789ABCDEF, 1, 0, "dec_u16", got);
        do_op(2, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405, 1, 0, "enc1_u16", got);

        // abort: drop req during RUN, result must not change
        sel  = 0;
        k    = 64'h133457799BBCDFF1;
        m    = 64'h8787878787878787;
        dec  = 1'b0;
        req1 = 1'b1;
        @(posedge clk);
        repeat (7) @(negedge clk);
        check("abort_busy_run", 64'(busy1), 64'd1);
        req1 = 1'b0;
        @(negedge clk);
        check("abort_busy_low", 64'(busy1), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        check("abort_no_ack", 64'(seen), 64'd0);
        check("abort_c_keep", c1, 64'h85E813540F0AB405);

        // asynchronous reset in the middle of RUN
        req1 = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        check("rst_mid_busy_before", 64'(busy1), 64'd1);
        #2;
        rst  = 1'b0;
        req1 = 1'b0;
        #1;
        check("rst_mid_c", c1, 64'd0);
        check("rst_mid_ack", 64'(ack1), 64'd0);
        check("rst_mid_busy", 64'(busy1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op(0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405, 16, 0, "after_rst", got);

`ifdef DES_CBC_EN
        // do_op scrambles iv/chain after load, so set them before every call
        iv = '0; chain = 1'b0;
        do_op(0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'h85E813540F0AB405, 16, 0, "cbc_e1", got);
        iv = '0; chain = 1'b1;
        do_op(0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'd0, 16, 0, "cbc_e2", c2);
        iv = '0; chain = 1'b0;
        do_op(0, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 1'b1, 64'h0123456789ABCDEF, 16, 0, "cbc_d1", got);
        iv = '0; chain = 1'b1;
        do_op(0, 64'h133457799BBCDFF1, c2, 1'b1, 1'b1, 64'h0123456789ABCDEF, 16, 0, "cbc_d2", got);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
